// File: rtl/packet_rx_parser_if.sv
// Handshake bundles around packet_rx_parser: the serial receive word stream
// and the decoded node-info packet presented to the filter/neighbor logic.

interface pkt_rx_word_if #(
    parameter int unsigned WORD_WIDTH = 16
);
    logic                  rx_valid;
    logic                  rx_sop;
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_ready;

    modport master (
        output rx_valid,
        output rx_sop,
        output rx_data,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_sop,
        input  rx_data,
        output rx_ready
    );
endinterface

interface pkt_rx_info_if #(
    parameter int unsigned WORD_WIDTH = 16
);
    logic [2:0]            fPacketType;
    logic [WORD_WIDTH-1:0] fSourceID;
    logic [WORD_WIDTH-1:0] fDestinationID;
    logic [WORD_WIDTH-1:0] fSourceHops;
    logic [WORD_WIDTH-1:0] fEnergyLeft;
    logic [WORD_WIDTH-1:0] fQValue;
    logic [WORD_WIDTH-1:0] fChosenCH;
    logic [WORD_WIDTH-1:0] fHopsFromCH;
    logic                  iAmDestination;
    logic                  f_valid;
    logic                  f_ack;

    modport master (
        output fPacketType,
        output fSourceID,
        output fDestinationID,
        output fSourceHops,
        output fEnergyLeft,
        output fQValue,
        output fChosenCH,
        output fHopsFromCH,
        output iAmDestination,
        output f_valid,
        input  f_ack
    );

    modport slave (
        input  fPacketType,
        input  fSourceID,
        input  fDestinationID,
        input  fSourceHops,
        input  fEnergyLeft,
        input  fQValue,
        input  fChosenCH,
        input  fHopsFromCH,
        input  iAmDestination,
        input  f_valid,
        output f_ack
    );
endinterface

// File: rtl/packet_rx_parser.sv
// Assembles one fixed-format node-info packet from serial words, filters on
// type/destination and holds the decoded fields until acknowledged.
// Optional trailing checksum word enabled by defining PKT_RX_CHECKSUM_EN.

module packet_rx_parser #(
    parameter int unsigned           WORD_WIDTH = 16,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    pkt_rx_word_if.slave          rx,
    pkt_rx_info_if.master         info,
    output logic [7:0]            drop_count
);

`ifdef PKT_RX_CHECKSUM_EN
    localparam int unsigned      IDX_W    = 4;
    localparam logic [IDX_W-1:0] IDX_ONE  = 4'd1;
    localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;
`else
    localparam int unsigned      IDX_W    = 3;
    localparam logic [IDX_W-1:0] IDX_ONE  = 3'd1;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;
`endif

    localparam logic [WORD_WIDTH-1:0] ALL_ONES = {WORD_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt == 8'hFF) begin
            return 8'hFF;
        end else begin
            return cnt + 8'd1;
        end
    endfunction

`ifdef PKT_RX_CHECKSUM_EN
    function automatic logic [WORD_WIDTH-1:0] csum_add(
        input logic [WORD_WIDTH-1:0] acc,
        input logic [WORD_WIDTH-1:0] word
    );
        return acc + word;
    endfunction
`endif

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   rx_ready_r;
    logic                   f_valid_r;
    logic [7:0]             drop_r;

    // Shadow copies of the packet in flight
    logic [2:0]             sh_type_r;
    logic [WORD_WIDTH-1:0]  sh_src_r;
    logic [WORD_WIDTH-1:0]  sh_dst_r;
    logic [WORD_WIDTH-1:0]  sh_hops_r;
    logic [WORD_WIDTH-1:0]  sh_energy_r;
    logic [WORD_WIDTH-1:0]  sh_q_r;
    logic [WORD_WIDTH-1:0]  sh_ch_r;
`ifdef PKT_RX_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]  sh_chh_r;
    logic [WORD_WIDTH-1:0]  sum_r;
`endif

    logic [2:0]             out_type_r;
    logic [WORD_WIDTH-1:0]  out_src_r;
    logic [WORD_WIDTH-1:0]  out_dst_r;
    logic [WORD_WIDTH-1:0]  out_hops_r;
    logic [WORD_WIDTH-1:0]  out_energy_r;
    logic [WORD_WIDTH-1:0]  out_q_r;
    logic [WORD_WIDTH-1:0]  out_ch_r;
    logic [WORD_WIDTH-1:0]  out_chh_r;
    logic                   out_iam_r;

    logic                   xfer_s;
    logic                   accept_s;
    logic [WORD_WIDTH-1:0]  last_chh_s;

    // Transfer qualification and acceptance of a completing packet
    always_comb begin
        xfer_s     = rx.rx_valid && rx_ready_r;
        accept_s   = (sh_type_r != 3'b111) &&
                     ((sh_dst_r == myNodeID) || (sh_dst_r == BCAST_ID));
`ifdef PKT_RX_CHECKSUM_EN
        accept_s   = accept_s && (rx.rx_data == sum_r);
        last_chh_s = sh_chh_r;
`else
        // Without a checksum the final word is the hops-from-CH field itself
        last_chh_s = rx.rx_data;
`endif
    end

    // Receive FSM, shadow capture, output latch and drop counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= S_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            rx_ready_r   <= 1'b1;
            f_valid_r    <= 1'b0;
            drop_r       <= 8'd0;
            sh_type_r    <= 3'b111;
            sh_src_r     <= ALL_ONES;
            sh_dst_r     <= ALL_ONES;
            sh_hops_r    <= ALL_ONES;
            sh_energy_r  <= ALL_ONES;
            sh_q_r       <= ALL_ONES;
            sh_ch_r      <= ALL_ONES;
`ifdef PKT_RX_CHECKSUM_EN
            sh_chh_r     <= ALL_ONES;
            sum_r        <= {WORD_WIDTH{1'b0}};
`endif
            out_type_r   <= 3'b111;
            out_src_r    <= ALL_ONES;
            out_dst_r    <= ALL_ONES;
            out_hops_r   <= ALL_ONES;
            out_energy_r <= ALL_ONES;
            out_q_r      <= ALL_ONES;
            out_ch_r     <= ALL_ONES;
            out_chh_r    <= ALL_ONES;
            out_iam_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (xfer_s && rx.rx_sop) begin
                        sh_type_r <= rx.rx_data[2:0];
`ifdef PKT_RX_CHECKSUM_EN
                        sum_r     <= rx.rx_data;
`endif
                        idx_r     <= IDX_ONE;
                        state_r   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (xfer_s) begin
                        if (rx.rx_sop) begin
                            // A new start word always wins, even in the last slot
                            drop_r    <= sat_inc(drop_r);
                            sh_type_r <= rx.rx_data[2:0];
`ifdef PKT_RX_CHECKSUM_EN
                            sum_r     <= rx.rx_data;
`endif
                            idx_r     <= IDX_ONE;
                        end else if (idx_r == LAST_IDX) begin
                            idx_r <= {IDX_W{1'b0}};
                            if (accept_s) begin
                                out_type_r   <= sh_type_r;
                                out_src_r    <= sh_src_r;
                                out_dst_r    <= sh_dst_r;
                                out_hops_r   <= sh_hops_r;
                                out_energy_r <= sh_energy_r;
                                out_q_r      <= sh_q_r;
                                out_ch_r     <= sh_ch_r;
                                out_chh_r    <= last_chh_s;
                                out_iam_r    <= (sh_dst_r == myNodeID);
                                f_valid_r    <= 1'b1;
                                rx_ready_r   <= 1'b0;
                                state_r      <= S_HOLD;
                            end else begin
                                drop_r  <= sat_inc(drop_r);
                                state_r <= S_IDLE;
                            end
                        end else begin
                            case (idx_r[2:0])
                                3'd1:    sh_src_r    <= rx.rx_data;
                                3'd2:    sh_dst_r    <= rx.rx_data;
                                3'd3:    sh_hops_r   <= rx.rx_data;
                                3'd4:    sh_energy_r <= rx.rx_data;
                                3'd5:    sh_q_r      <= rx.rx_data;
                                3'd6:    sh_ch_r     <= rx.rx_data;
`ifdef PKT_RX_CHECKSUM_EN
                                3'd7:    sh_chh_r    <= rx.rx_data;
`endif
                                default: sh_src_r    <= sh_src_r;
                            endcase
`ifdef PKT_RX_CHECKSUM_EN
                            sum_r <= csum_add(sum_r, rx.rx_data);
`endif
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                S_HOLD: begin
                    if (info.f_ack) begin
                        f_valid_r  <= 1'b0;
                        rx_ready_r <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    idx_r      <= {IDX_W{1'b0}};
                    f_valid_r  <= 1'b0;
                    rx_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign rx.rx_ready          = rx_ready_r;
    assign info.f_valid         = f_valid_r;
    assign info.fPacketType     = out_type_r;
    assign info.fSourceID       = out_src_r;
    assign info.fDestinationID  = out_dst_r;
    assign info.fSourceHops     = out_hops_r;
    assign info.fEnergyLeft     = out_energy_r;
    assign info.fQValue         = out_q_r;
    assign info.fChosenCH       = out_ch_r;
    assign info.fHopsFromCH     = out_chh_r;
    assign info.iAmDestination  = out_iam_r;
    assign drop_count           = drop_r;

endmodule

// File: tb/tb_packet_rx_parser.sv
// Directed scoreboard bench for packet_rx_parser; follows PKT_RX_CHECKSUM_EN
// when it is defined for the build.

module tb_packet_rx_parser;

    typedef struct {
        logic [2:0]  t;
        logic [15:0] src, dst, hops, en, q, ch, chh;
        logic        iam;
    } pkt_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] my_id = 16'h0005;
    logic [7:0]  drop_count;

    pkt_rx_word_if #(.WORD_WIDTH(16)) rx_if ();
    pkt_rx_info_if #(.WORD_WIDTH(16)) info_if ();

    packet_rx_parser dut (
        .clk        (clk),
        .nrst       (nrst),
        .myNodeID   (my_id),
        .rx         (rx_if),
        .info       (info_if),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   gap_max = 0;
    int   exp_drop = 0;
    pkt_t exp_q[$];
    pkt_t last_acc;
    pkt_t rst_pkt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input pkt_t p);
        check({tag, ".type"}, 32'(info_if.fPacketType), 32'(p.t));
        check({tag, ".src"},  32'(info_if.fSourceID), 32'(p.src));
        check({tag, ".dst"},  32'(info_if.fDestinationID), 32'(p.dst));
        check({tag, ".hops"}, 32'(info_if.fSourceHops), 32'(p.hops));
        check({tag, ".en"},   32'(info_if.fEnergyLeft), 32'(p.en));
        check({tag, ".q"},    32'(info_if.fQValue), 32'(p.q));
        check({tag, ".ch"},   32'(info_if.fChosenCH), 32'(p.ch));
        check({tag, ".chh"},  32'(info_if.fHopsFromCH), 32'(p.chh));
        check({tag, ".iam"},  32'(info_if.iAmDestination), 32'(p.iam));
    endtask

    function automatic pkt_t mk(input logic [2:0] t, input logic [15:0] src, dst, hops,
                                input logic [15:0] en, q, ch, chh);
        pkt_t p;
        p.t = t; p.src = src; p.dst = dst; p.hops = hops;
        p.en = en; p.q = q; p.ch = ch; p.chh = chh;
        p.iam = 1'b0;
        return p;
    endfunction

    task automatic send_word(input logic sop, input logic [15:0] d);
        int guard;
        if (gap_max > 0) begin
            repeat ($urandom_range(gap_max, 0)) begin
                rx_if.rx_valid = 1'b0;
                tick();
            end
        end
        rx_if.rx_valid = 1'b1;
        rx_if.rx_sop   = sop;
        rx_if.rx_data  = d;
        guard = 0;
        while (rx_if.rx_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("rx_ready_wait", 32'(rx_if.rx_ready), 32'd1);
        tick();
        rx_if.rx_valid = 1'b0;
        rx_if.rx_sop   = 1'b0;
    endtask

    // Sends the first nwords of p (full frame when nwords >= frame length) and
    // checks the outcome of a complete frame against the model.
    task automatic send_pkt(input string tag, input pkt_t p, input bit exp_ok,
                            input int nwords, input bit cs_bad);
        logic [15:0] w[9];
        logic [15:0] sum;
        int          nfull;
        pkt_t        e;
        w[0] = {13'h0B3D, p.t};
        w[1] = p.src; w[2] = p.dst; w[3] = p.hops; w[4] = p.en;
        w[5] = p.q;   w[6] = p.ch;  w[7] = p.chh;
        sum = 16'd0;
        for (int i = 0; i < 8; i++) sum = sum + w[i];
        w[8] = cs_bad ? (sum + 16'd1) : sum;
`ifdef PKT_RX_CHECKSUM_EN
        nfull = 9;
`else
        nfull = 8;
`endif
        for (int i = 0; i < nfull && i < nwords; i++) send_word(i == 0, w[i]);
        if (nwords >= nfull) begin
            if (exp_ok) begin
                p.iam = (p.dst == my_id);
                exp_q.push_back(p);
                check({tag, ".f_valid"}, 32'(info_if.f_valid), 32'd1);
                check({tag, ".rx_ready"}, 32'(rx_if.rx_ready), 32'd0);
                if (exp_q.size() > 0 && info_if.f_valid === 1'b1) begin
                    e = exp_q.pop_front();
                    check_out(tag, e);
                    last_acc = e;
                end
            end else begin
                if (exp_drop < 255) exp_drop++;
                check({tag, ".f_valid"}, 32'(info_if.f_valid), 32'd0);
                check_out({tag, ".held"}, last_acc);
            end
            check({tag, ".drop"}, 32'(drop_count), 32'(exp_drop));
        end
    endtask

    task automatic ack(input string tag);
        info_if.f_ack = 1'b1;
        tick();
        info_if.f_ack = 1'b0;
        check({tag, ".f_valid_clr"}, 32'(info_if.f_valid), 32'd0);
        check({tag, ".rx_ready_ret"}, 32'(rx_if.rx_ready), 32'd1);
    endtask

    initial begin
        pkt_t a, b;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_sop   = 1'b0;
        rx_if.rx_data  = 16'h0000;
        info_if.f_ack  = 1'b0;
        rst_pkt = mk(3'b111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        last_acc = rst_pkt;
        repeat (3) tick();
        nrst = 1'b1;
        tick();

        // Reset state
        check("rst.rx_ready", 32'(rx_if.rx_ready), 32'd1);
        check("rst.f_valid", 32'(info_if.f_valid), 32'd0);
        check("rst.drop", 32'(drop_count), 32'd0);
        check_out("rst", rst_pkt);

        // Unicast accept, then backpressure while held
        send_pkt("uni", mk(3'b101, 16'd3, 16'd5, 16'd2, 16'h0200, 16'h0010, 16'd7, 16'd1), 1'b1, 9, 1'b0);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_sop   = 1'b1;
        rx_if.rx_data  = 16'h00AA;
        repeat (20) tick();
        check("bp.rx_ready", 32'(rx_if.rx_ready), 32'd0);
        check("bp.f_valid", 32'(info_if.f_valid), 32'd1);
        check("bp.drop", 32'(drop_count), 32'(exp_drop));
        check_out("bp", last_acc);
        rx_if.rx_valid = 1'b0;
        rx_if.rx_sop   = 1'b0;
        ack("uni");

        // Broadcast heartbeat, then reserved type rejected
        send_pkt("bcast", mk(3'b000, 16'd4, 16'hFFFF, 16'd1, 16'h0100, 16'h0020, 16'd4, 16'd0), 1'b1, 9, 1'b0);
        ack("bcast");
        send_pkt("type7", mk(3'b111, 16'd6, 16'd5, 16'd3, 16'h0050, 16'h0001, 16'd2, 16'd2), 1'b0, 9, 1'b0);

        // Address reject followed by a normal accept
        send_pkt("addr", mk(3'b010, 16'd8, 16'h0009, 16'd1, 16'h0300, 16'h0002, 16'd8, 16'd3), 1'b0, 9, 1'b0);
        send_pkt("after", mk(3'b011, 16'h0A0A, 16'd5, 16'd4, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), 1'b1, 9, 1'b0);
        ack("after");

        // Stray words in idle are not counted
        for (int i = 0; i < 3; i++) send_word(1'b0, 16'h0F00 + 16'(i));
        check("stray.drop", 32'(drop_count), 32'(exp_drop));
        check("stray.f_valid", 32'(info_if.f_valid), 32'd0);

        // Abort on W4: packet B's start word takes A's W4 slot
        a = mk(3'b001, 16'h1111, 16'd5, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
        b = mk(3'b100, 16'h7001, 16'd5, 16'h7003, 16'h7004, 16'h7005, 16'h7006, 16'h7007);
        send_pkt("abortA", a, 1'b0, 4, 1'b0);
        exp_drop++;
        send_pkt("abortB", b, 1'b1, 9, 1'b0);
        ack("abortB");

        // Start word in the final slot restarts, with gaps between words
        gap_max = 3;
        send_pkt("lastA", a, 1'b0, 7, 1'b0);
        exp_drop++;
        send_pkt("lastB", mk(3'b110, 16'h0C01, 16'hFFFF, 16'h0C03, 16'h0C04, 16'h0C05, 16'h0C06, 16'h0C07), 1'b1, 9, 1'b0);
        ack("lastB");
        gap_max = 0;

        // Ack already high: one cycle in hold
        info_if.f_ack = 1'b1;
        send_pkt("fast", mk(3'b010, 16'h00F1, 16'd5, 16'd9, 16'h0009, 16'h0008, 16'h0007, 16'h0006), 1'b1, 9, 1'b0);
        tick();
        check("fast.f_valid_clr", 32'(info_if.f_valid), 32'd0);
        check("fast.rx_ready", 32'(rx_if.rx_ready), 32'd1);
        info_if.f_ack = 1'b0;

`ifdef PKT_RX_CHECKSUM_EN
        send_pkt("cs_bad", mk(3'b001, 16'h0101, 16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5), 1'b0, 9, 1'b1);
        send_pkt("cs_ok", mk(3'b001, 16'h0101, 16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5), 1'b1, 9, 1'b0);
        ack("cs_ok");
`endif

        // Saturate the drop counter
        for (int i = 0; i < 260; i++)
            send_pkt("sat", mk(3'b111, 16'd1, 16'd5, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1), 1'b0, 9, 1'b0);
        check("sat.drop", 32'(drop_count), 32'hFF);
        send_pkt("sat_hold", mk(3'b001, 16'd1, 16'h0777, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1), 1'b0, 9, 1'b0);

        // Reset mid-packet after W3
        send_pkt("rstA", a, 1'b0, 4, 1'b0);
        nrst = 1'b0;
        #1;
        check("mid_rst.rx_ready", 32'(rx_if.rx_ready), 32'd1);
        check("mid_rst.f_valid", 32'(info_if.f_valid), 32'd0);
        check("mid_rst.drop", 32'(drop_count), 32'd0);
        check_out("mid_rst", rst_pkt);
        tick();
        nrst = 1'b1;
        exp_drop = 0;
        last_acc = rst_pkt;
        tick();
        send_pkt("post_rst", b, 1'b1, 9, 1'b0);
        ack("post_rst");
        check("post_rst.q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
